// File: rtl/cube_rr_scheduler.sv
// cube_rr_scheduler
//   Shares one two-stage pipelined 8-bit cube datapath (out = in^3, 24-bit result)
//   between NREQ requesters. A round-robin arbiter grants one requester per cycle.
//   The requester ID travels with the operand, so every result comes back tagged
//   with the ID of the requester that issued it.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   rst        asynchronous active-high reset
//   en         issue enable; 0 blocks new grants, but in-flight operations still drain
//   req        per-requester request, held until granted
//   req_data   operands; requester i drives bits [8i+7:8i]
//   grant      one-hot grant (combinational); the operand is accepted this cycle
//   out_valid  one-cycle pulse per finished operation
//   out_id     requester ID of the result
//   out_data   cube of the operand
//   busy       high while any operation is in flight
//   issue_cnt  number of operations issued since reset (wraps)
module cube_rr_scheduler #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned CNTW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   grant,
  output logic              out_valid,
  output logic [IDW-1:0]    out_id,
  output logic [23:0]       out_data,
  output logic              busy,
  output logic [CNTW-1:0]   issue_cnt
);

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic [7:0]      gnt_op;
  int unsigned     idx;

  logic            s1_valid_q;
  logic [IDW-1:0]  s1_id_q;
  logic [7:0]      s1_op_q;
  logic [15:0]     s1_sq_q;

  logic            s2_valid_q;
  logic [IDW-1:0]  s2_id_q;
  logic [23:0]     s2_data_q;
  logic [CNTW-1:0] cnt_q;

  // Search ptr, ptr+1, ... modulo NREQ. The first requester found wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    if (!rst && en) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = (32'(ptr_q) + k) % NREQ;
        if (!gnt_any && req[idx]) begin
          grant[idx] = 1'b1;
          gnt_idx    = IDW'(idx);
          gnt_any    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = IDW'((32'(gnt_idx) + 32'd1) % NREQ);
    end
  end

  assign gnt_op = req_data[8*gnt_idx +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_op_q    <= '0;
      s1_sq_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_data_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= gnt_any;
      s2_valid_q <= s1_valid_q;
      if (gnt_any) begin
        cnt_q   <= cnt_q + CNTW'(1);
        s1_id_q <= gnt_idx;
        s1_op_q <= gnt_op;
        s1_sq_q <= 16'(gnt_op) * 16'(gnt_op);
      end
      // The result registers update only on a valid operation, so they hold
      // their last value between pulses.
      if (s1_valid_q) begin
        s2_id_q   <= s1_id_q;
        s2_data_q <= 24'(s1_sq_q) * 24'(s1_op_q);
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_id    = s2_id_q;
  assign out_data  = s2_data_q;
  assign busy      = s1_valid_q | s2_valid_q;
  assign issue_cnt = cnt_q;

endmodule
